// File: rtl/obi_arbiter_pkg.sv
// Shared definitions for the two-master OBI arbiter: source IDs, bus widths
// and the packed request-channel bundle driven onto the slave port.
package obi_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam logic SRC_INSTR = 1'b0;
    localparam logic SRC_DATA  = 1'b1;

    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_chan_t;

    // Fetches are always full-word reads.
    function automatic req_chan_t instr_chan(input logic [ADDR_W-1:0] addr);
        req_chan_t c;
        c       = '0;
        c.addr  = addr;
        c.be    = '1;
        return c;
    endfunction

endpackage

// File: rtl/id_fifo.sv
// In-order FIFO of source IDs for transactions accepted by the slave but not
// yet answered. Pointers wrap modulo DEPTH; count runs 0..DEPTH.
module id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: the storage is small and a reset must discard every outstanding
    // ID, so the array is cleared along with the pointers rather than left
    // holding stale values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/obi_arbiter.sv
// Round-robin arbiter sharing one OBI slave between an instruction and a data
// master. Requests pass through combinationally; responses are routed back
// using an in-order FIFO of source IDs.
module obi_arbiter
    import obi_arbiter_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int DATA_PRIO = 1
) (
    input  logic              clk,
    input  logic              rstn,

    input  logic              instr_req,
    output logic              instr_gnt,
    output logic              instr_rvalid,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic [DATA_W-1:0] instr_rdata,

    input  logic              data_req,
    input  logic              data_we,
    output logic              data_gnt,
    output logic              data_rvalid,
    input  logic [BE_W-1:0]   data_be,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,

    output logic              s_req,
    output logic              s_we,
    output logic [BE_W-1:0]   s_be,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic              s_gnt,
    input  logic              s_rvalid,
    input  logic [DATA_W-1:0] s_rdata,

    output logic              err
);

    logic      rr_ptr;
    logic      winner;
    logic      accept;
    logic      pop;
    logic      head_id;
    logic      fifo_empty;
    logic      fifo_full;
    req_chan_t chan;

    // A full FIFO blocks new requests even if a response frees a slot in the
    // same cycle; this keeps s_req independent of s_rvalid.
    assign s_req  = (instr_req | data_req) & ~fifo_full;
    assign accept = s_req & s_gnt;
    assign pop    = s_rvalid & ~fifo_empty;

    // NOTE: every always_comb output gets a default before any branch so
    // that no path leaves it unassigned, which would infer a latch.
    always_comb begin
        winner = SRC_INSTR;
        if (instr_req && data_req) begin
            winner = rr_ptr;
        end else if (data_req) begin
            winner = SRC_DATA;
        end
    end

    always_comb begin
        chan = '0;
        if (s_req) begin
            if (winner == SRC_DATA) begin
                chan.we    = data_we;
                chan.be    = data_be;
                chan.addr  = data_addr;
                chan.wdata = data_wdata;
            end else begin
                chan = instr_chan(instr_addr);
            end
        end
    end

    assign s_we    = chan.we;
    assign s_be    = chan.be;
    assign s_addr  = chan.addr;
    assign s_wdata = chan.wdata;

    assign instr_gnt = accept & (winner == SRC_INSTR);
    assign data_gnt  = accept & (winner == SRC_DATA);

    assign instr_rvalid = pop & (head_id == SRC_INSTR);
    assign data_rvalid  = pop & (head_id == SRC_DATA);
    assign instr_rdata  = s_rdata;
    assign data_rdata   = s_rdata;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr <= (DATA_PRIO != 0) ? SRC_DATA : SRC_INSTR;
        end else if (accept) begin
            rr_ptr <= ~winner;
        end
    end

    // A response with nothing outstanding means the slave broke protocol.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err <= 1'b0;
        end else if (s_rvalid && fifo_empty) begin
            err <= 1'b1;
        end
    end

    id_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (1)
    ) u_id_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (accept),
        .push_data (winner),
        .pop       (pop),
        .pop_data  (head_id),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_obi_arbiter.sv
// Directed and randomized bench for obi_arbiter, checked against a queue-based
// model of the outstanding transactions and the favoured master.
module tb_obi_arbiter;

    localparam int DEPTH     = 2;
    localparam int DATA_PRIO = 1;

    logic        clk = 1'b0;
    logic        rstn;
    logic        instr_req, instr_gnt, instr_rvalid;
    logic [31:0] instr_addr, instr_rdata;
    logic        data_req, data_we, data_gnt, data_rvalid;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        s_req, s_we, s_gnt, s_rvalid;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        err;

    obi_arbiter #(
        .DEPTH     (DEPTH),
        .DATA_PRIO (DATA_PRIO)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .instr_req    (instr_req),
        .instr_gnt    (instr_gnt),
        .instr_rvalid (instr_rvalid),
        .instr_addr   (instr_addr),
        .instr_rdata  (instr_rdata),
        .data_req     (data_req),
        .data_we      (data_we),
        .data_gnt     (data_gnt),
        .data_rvalid  (data_rvalid),
        .data_be      (data_be),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .s_req        (s_req),
        .s_we         (s_we),
        .s_be         (s_be),
        .s_addr       (s_addr),
        .s_wdata      (s_wdata),
        .s_gnt        (s_gnt),
        .s_rvalid     (s_rvalid),
        .s_rdata      (s_rdata),
        .err          (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: who is still owed a response, who wins a tie, sticky error.
    bit id_q[$];
    bit favour_data;
    bit err_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_idle(input logic gnt);
        instr_req  = 1'b0;
        instr_addr = '0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_be    = '0;
        data_addr  = '0;
        data_wdata = '0;
        s_gnt      = gnt;
        s_rvalid   = 1'b0;
        s_rdata    = '0;
    endtask

    task automatic compare_model();
        bit          may_issue;
        bit          win_data;
        bit          head_valid;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        logic        e_we;
        may_issue  = (instr_req || data_req) && (id_q.size() < DEPTH);
        win_data   = data_req && (!instr_req || favour_data);
        head_valid = s_rvalid && (id_q.size() > 0);
        e_addr = '0; e_wdata = '0; e_be = '0; e_we = 1'b0;
        if (may_issue && win_data) begin
            e_addr = data_addr; e_wdata = data_wdata; e_be = data_be; e_we = data_we;
        end else if (may_issue) begin
            e_addr = instr_addr; e_be = 4'hF;
        end
        check("s_req",        s_req,        may_issue);
        check("s_addr",       s_addr,       e_addr);
        check("s_we",         s_we,         e_we);
        check("s_be",         s_be,         e_be);
        check("s_wdata",      s_wdata,      e_wdata);
        check("instr_gnt",    instr_gnt,    may_issue && s_gnt && !win_data);
        check("data_gnt",     data_gnt,     may_issue && s_gnt && win_data);
        check("instr_rvalid", instr_rvalid, head_valid && (id_q[0] == 1'b0));
        check("data_rvalid",  data_rvalid,  head_valid && (id_q[0] == 1'b1));
        check("instr_rdata",  instr_rdata,  s_rdata);
        check("data_rdata",   data_rdata,   s_rdata);
        check("err",          err,          err_m);
    endtask

    task automatic clock_edge();
        bit accepted;
        bit win_data;
        bit had_any;
        accepted = (instr_req || data_req) && (id_q.size() < DEPTH) && s_gnt;
        win_data = data_req && (!instr_req || favour_data);
        had_any  = (id_q.size() > 0);
        @(posedge clk);
        if (s_rvalid && had_any) void'(id_q.pop_front());
        else if (s_rvalid) err_m = 1'b1;
        if (accepted) begin
            id_q.push_back(win_data);
            favour_data = !win_data;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        set_idle(1'b1);
        #1;
        check("rst_async_err", err, 1'b0);
        check("rst_s_req", s_req, 1'b0);
        id_q.delete();
        favour_data = (DATA_PRIO != 0);
        err_m = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        set_idle(1'b1);
        do_reset();

        // Idle after reset with the slave ready: everything stays quiet.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); set_idle(1'b1); #1;
            compare_model();
            check("idle_s_req", s_req, 1'b0);
            check("idle_s_addr", s_addr, 32'h0);
            clock_edge();
        end

        // Lone data write drives the slave channel verbatim.
        @(negedge clk);
        set_idle(1'b1);
        data_req = 1'b1; data_we = 1'b1; data_be = 4'b0011;
        data_addr = 32'h100; data_wdata = 32'hDEADBEEF;
        #1;
        compare_model();
        check("wr_addr",  s_addr,  32'h100);
        check("wr_we",    s_we,    1'b1);
        check("wr_be",    s_be,    4'b0011);
        check("wr_wdata", s_wdata, 32'hDEADBEEF);
        check("wr_dgnt",  data_gnt,  1'b1);
        check("wr_ignt",  instr_gnt, 1'b0);
        clock_edge();
        @(negedge clk); set_idle(1'b1); s_rvalid = 1'b1; s_rdata = 32'h1234; #1;
        compare_model();
        check("wr_resp", data_rvalid, 1'b1);
        clock_edge();

        // Both masters every cycle with a one-cycle slave: strict alternation.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_idle(1'b1);
            instr_req = 1'b1; instr_addr = 32'h1000 + 32'(4 * i);
            data_req = 1'b1; data_addr = 32'h2000 + 32'(4 * i); data_be = 4'hF;
            s_rvalid = (i > 0); s_rdata = $urandom;
            #1;
            compare_model();
            check("alt_dgnt", data_gnt, (i % 2) == 0);
            check("alt_ignt", instr_gnt, (i % 2) == 1);
            if (i > 0) begin
                check("alt_drv", data_rvalid, ((i - 1) % 2) == 0);
                check("alt_irv", instr_rvalid, ((i - 1) % 2) == 1);
            end
            clock_edge();
        end

        // Back-pressure: DEPTH grants, then blocked until a response drains one.
        do_reset();
        for (int i = 0; i < DEPTH + 4; i++) begin
            @(negedge clk);
            set_idle(1'b1);
            data_req = 1'b1; data_addr = 32'h3000 + 32'(i);
            s_rvalid = (i == DEPTH + 2);
            #1;
            compare_model();
            check("full_s_req", s_req, (i < DEPTH) || (i == DEPTH + 3));
            check("full_dgnt", data_gnt, (i < DEPTH) || (i == DEPTH + 3));
            check("full_drv", data_rvalid, i == DEPTH + 2);
            clock_edge();
        end

        // Spurious response sets a sticky error, cleared only by reset.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); set_idle(1'b0); s_rvalid = (i == 0); #1;
            compare_model();
            check("spur_irv", instr_rvalid, 1'b0);
            check("spur_drv", data_rvalid, 1'b0);
            check("spur_err", err, i > 0);
            clock_edge();
        end

        // Reset with transactions outstanding forgets them.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); set_idle(1'b1); data_req = 1'b1; #1;
            compare_model();
            clock_edge();
        end
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); set_idle(1'b0); s_rvalid = (i == 0); #1;
            compare_model();
            check("rst_drop_drv", data_rvalid, 1'b0);
            check("rst_drop_err", err, i > 0);
            clock_edge();
        end

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            instr_req  = ($urandom_range(0, 99) < 60);
            instr_addr = $urandom;
            data_req   = ($urandom_range(0, 99) < 60);
            data_we    = $urandom_range(0, 1);
            data_be    = 4'($urandom);
            data_addr  = $urandom;
            data_wdata = $urandom;
            s_gnt      = ($urandom_range(0, 99) < 70);
            s_rvalid   = (id_q.size() > 0) ? ($urandom_range(0, 99) < 50)
                                           : ($urandom_range(0, 199) == 0);
            s_rdata    = $urandom;
            #1;
            compare_model();
            clock_edge();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
